// File: rtl/arbitro_rr_fifo.sv
// Round-robin scheduler draining four source FIFOs into one destination FIFO,
// with burst quota per source, almost_full backpressure and sticky error halt.
module arbitro_rr_fifo #(
  parameter int tamano_datos = 10,
  parameter int rafaga       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                empty,
  input  logic [3:0]                error_fifo,
  input  logic [4*tamano_datos-1:0] data_fifo,
  input  logic                      almost_full_dest,
  output logic [3:0]                pop,
  output logic                      push,
  output logic [tamano_datos-1:0]   data_out,
  output logic [1:0]                grant,
  output logic [1:0]                estado,
  output logic                      error
);

  localparam int CW = $clog2(rafaga + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVO = 2'd1,
    PAUSA  = 2'd2,
    ERROR  = 2'd3
  } estado_t;

  estado_t                 estado_q, estado_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [1:0]              grant_q, grant_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    push_q, push_d;
  logic [tamano_datos-1:0] data_q, data_d;
  logic                    error_q, error_d;

  logic [1:0] cand;
  logic [1:0] idx;
  logic       hay_cand;
  logic       permitido;
  logic       do_pop;

  // Keep the current source while it has quota; otherwise scan ptr+1..ptr+4,
  // where ptr+4 wraps back to ptr so a lone requester is never starved.
  always_comb begin
    cand     = ptr_q;
    idx      = ptr_q;
    hay_cand = 1'b0;
    if ((cnt_q < CW'(rafaga)) && !empty[ptr_q]) begin
      cand     = ptr_q;
      hay_cand = 1'b1;
    end else begin
      for (int k = 4; k >= 1; k--) begin
        idx = ptr_q + 2'(k);
        if (!empty[idx]) begin
          cand     = idx;
          hay_cand = 1'b1;
        end
      end
    end
  end

  assign permitido = !reset && (estado_q != ERROR) && !(|error_fifo) &&
                     !almost_full_dest && (empty != 4'b1111);
  assign do_pop    = permitido && hay_cand;
  assign pop       = do_pop ? (4'b0001 << cand) : 4'b0000;

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    data_d  = data_q;
    push_d  = do_pop;
    if (do_pop) begin
      ptr_d   = cand;
      grant_d = cand;
      data_d  = data_fifo[cand*tamano_datos +: tamano_datos];
      if (cand == ptr_q)
        cnt_d = (cnt_q >= CW'(rafaga)) ? CW'(rafaga) : cnt_q + CW'(1);
      else
        cnt_d = CW'(1);
    end

    if ((|error_fifo) || (estado_q == ERROR))
      estado_d = ERROR;
    else if (do_pop)
      estado_d = ACTIVO;
    else if (almost_full_dest && (empty != 4'b1111))
      estado_d = PAUSA;
    else
      estado_d = IDLE;

    error_d = error_q | (estado_d == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      push_q   <= 1'b0;
      data_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      push_q   <= push_d;
      data_q   <= data_d;
      error_q  <= error_d;
    end
  end

  assign push     = push_q;
  assign data_out = data_q;
  assign grant    = grant_q;
  assign estado   = estado_q;
  assign error    = error_q;

endmodule
